// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: opcodes, extender/ALU modes, states.
// Pure constants and types; no logic, no latency.
package mc_ctrl_pkg;

   localparam int ExtOp_WIDTH = 2;
   localparam logic [ExtOp_WIDTH-1:0] ExtOp_SIGNED = 2'd0;
   localparam logic [ExtOp_WIDTH-1:0] ExtOp_UNSIGN = 2'd1;
   localparam logic [ExtOp_WIDTH-1:0] ExtOp_HIGH16 = 2'd2;

   localparam int AluOp_WIDTH = 2;
   localparam logic [AluOp_WIDTH-1:0] AluOp_ADD = 2'd0;
   localparam logic [AluOp_WIDTH-1:0] AluOp_OR  = 2'd1;
   localparam logic [AluOp_WIDTH-1:0] AluOp_AND = 2'd2;

   localparam logic [5:0] OP_ADDI  = 6'd14;
   localparam logic [5:0] OP_ADDIS = 6'd15;
   localparam logic [5:0] OP_B     = 6'd18;
   localparam logic [5:0] OP_ORI   = 6'd24;
   localparam logic [5:0] OP_ORIS  = 6'd25;
   localparam logic [5:0] OP_ANDI  = 6'd28;
   localparam logic [5:0] OP_LWZ   = 6'd32;
   localparam logic [5:0] OP_STW   = 6'd36;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef struct packed {
      logic [ExtOp_WIDTH-1:0] ext_op;
      logic [AluOp_WIDTH-1:0] alu_op;
      logic                   is_mem;
      logic                   is_store;
      logic                   is_branch;
      logic                   illegal;
   } dec_t;

   function automatic logic [5:0] opcode_of(input logic [31:0] ir);
      return ir[31:26];
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode decode into extender mode, ALU op and instruction class flags.
// Zero latency; no handshake.
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   output dec_t       dec
);

   always_comb begin
      dec           = '0;
      dec.ext_op    = ExtOp_SIGNED;
      dec.alu_op    = AluOp_ADD;
      case (opcode)
         OP_ADDI: begin
            dec.ext_op = ExtOp_SIGNED;
            dec.alu_op = AluOp_ADD;
         end
         OP_ADDIS: begin
            dec.ext_op = ExtOp_HIGH16;
            dec.alu_op = AluOp_ADD;
         end
         OP_ORI: begin
            dec.ext_op = ExtOp_UNSIGN;
            dec.alu_op = AluOp_OR;
         end
         OP_ORIS: begin
            dec.ext_op = ExtOp_HIGH16;
            dec.alu_op = AluOp_OR;
         end
         OP_ANDI: begin
            dec.ext_op = ExtOp_UNSIGN;
            dec.alu_op = AluOp_AND;
         end
         OP_LWZ: begin
            dec.is_mem = 1'b1;
         end
         OP_STW: begin
            dec.is_mem   = 1'b1;
            dec.is_store = 1'b1;
         end
         OP_B: begin
            dec.is_branch = 1'b1;
         end
         default: begin
            // Illegal opcodes must not leak a mode onto the datapath.
            dec.ext_op  = '0;
            dec.alu_op  = '0;
            dec.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with retired-instruction counter.
// 3-5 cycles per instruction; FETCH and MEM stall while mem_ready is low.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int INSTRET_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            instr,
   input  logic                   mem_ready,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic                   addr_sel,
   output logic                   ir_we,
   output logic                   pc_we,
   output logic                   pc_src,
   output logic                   rf_we,
   output logic                   wb_sel,
   output logic [ExtOp_WIDTH-1:0] ext_op,
   output logic [1:0]             alu_op,
   output logic                   illegal,
   output logic [2:0]             state,
   output logic [INSTRET_W-1:0]   instret
);

   state_t                 state_q;
   state_t                 state_d;
   logic [INSTRET_W-1:0]   instret_q;
   logic                   retire;
   dec_t                   dec;

   // Only the opcode field steers control; the rest of the IR belongs to the datapath.
   logic unused_instr_bits;
   assign unused_instr_bits = ^instr[25:0];

   mc_decode u_decode (
      .opcode (opcode_of(instr)),
      .dec    (dec)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) begin
            instret_q <= instret_q + INSTRET_W'(1);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      retire   = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = 1'b0;
      ext_op   = '0;
      alu_op   = '0;
      illegal  = 1'b0;

      case (state_q)
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            ext_op  = dec.ext_op;
            alu_op  = dec.alu_op;
            state_d = dec.illegal ? ST_TRAP : ST_EXEC;
         end
         ST_EXEC: begin
            ext_op = dec.ext_op;
            alu_op = dec.alu_op;
            if (dec.is_branch) begin
               pc_we   = 1'b1;
               pc_src  = 1'b1;
               retire  = 1'b1;
               state_d = ST_FETCH;
            end else if (dec.is_mem) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            ext_op   = dec.ext_op;
            alu_op   = dec.alu_op;
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = dec.is_store;
            if (mem_ready) begin
               if (dec.is_store) begin
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            ext_op  = dec.ext_op;
            alu_op  = dec.alu_op;
            rf_we   = 1'b1;
            wb_sel  = dec.is_mem;
            retire  = 1'b1;
            state_d = ST_FETCH;
         end
         ST_TRAP: begin
            illegal = 1'b1;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase

      // Reset abandons any access in the same cycle and suppresses retirement.
      if (rst) begin
         retire   = 1'b0;
         mem_req  = 1'b0;
         mem_we   = 1'b0;
         addr_sel = 1'b0;
         ir_we    = 1'b0;
         pc_we    = 1'b0;
         pc_src   = 1'b0;
         rf_we    = 1'b0;
         wb_sel   = 1'b0;
         ext_op   = '0;
         alu_op   = '0;
      end
   end

   assign state   = state_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed and randomized instruction streams against a per-instruction phase model.
// Counter is narrowed to 8 bits so natural instruction flow exercises the wrap.
module tb_mc_ctrl;

   localparam int W = 8;

   localparam int S_FETCH  = 0;
   localparam int S_DECODE = 1;
   localparam int S_EXEC   = 2;
   localparam int S_MEM    = 3;
   localparam int S_WB     = 4;
   localparam int S_TRAP   = 5;

   logic         clk;
   logic         rst;
   logic [31:0]  instr;
   logic         mem_ready;
   logic         mem_req;
   logic         mem_we;
   logic         addr_sel;
   logic         ir_we;
   logic         pc_we;
   logic         pc_src;
   logic         rf_we;
   logic         wb_sel;
   logic [1:0]   ext_op;
   logic [1:0]   alu_op;
   logic         illegal;
   logic [2:0]   state;
   logic [W-1:0] instret;

   int n_cmp;
   int n_err;
   int cnt_m;

   mc_ctrl #(.INSTRET_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .instr     (instr),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .addr_sel  (addr_sel),
      .ir_we     (ir_we),
      .pc_we     (pc_we),
      .pc_src    (pc_src),
      .rf_we     (rf_we),
      .wb_sel    (wb_sel),
      .ext_op    (ext_op),
      .alu_op    (alu_op),
      .illegal   (illegal),
      .state     (state),
      .instret   (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Instruction-set table: legality, extender mode, ALU op and class.
   function automatic void op_info(input logic [5:0] op, output bit legal,
                                   output logic [1:0] ext, output logic [1:0] alu,
                                   output bit ld, output bit sto, output bit br);
      legal = 1; ext = 0; alu = 0; ld = 0; sto = 0; br = 0;
      case (op)
         6'd14: begin ext = 0; alu = 0; end
         6'd15: begin ext = 2; alu = 0; end
         6'd24: begin ext = 1; alu = 1; end
         6'd25: begin ext = 2; alu = 1; end
         6'd28: begin ext = 1; alu = 2; end
         6'd32: ld = 1;
         6'd36: sto = 1;
         6'd18: br = 1;
         default: legal = 0;
      endcase
   endfunction

   // One clock of a known phase: drive inputs, check outputs mid-cycle, advance.
   task automatic step(input int st, input bit rdy, input logic [31:0] ins);
      bit legal, ld, sto, br;
      logic [1:0] ext, alu;
      bit e_mreq, e_pcwe, e_rf;
      logic [4:0] e_strb;
      op_info(ins[31:26], legal, ext, alu, ld, sto, br);
      instr     = ins;
      mem_ready = rdy;
      @(negedge clk);
      e_mreq = (st == S_FETCH) || (st == S_MEM);
      e_pcwe = (st == S_FETCH && rdy) || (st == S_EXEC && br);
      e_rf   = (st == S_WB);
      e_strb = {e_mreq, (st == S_MEM) && sto, (st == S_FETCH) && rdy, e_pcwe, e_rf};
      chk("state", 32'(state), st);
      chk("strobes", 32'({mem_req, mem_we, ir_we, pc_we, rf_we}), 32'(e_strb));
      chk("illegal", 32'(illegal), 32'(st == S_TRAP));
      if (st == S_FETCH || st == S_TRAP) begin
         chk("ext_op_idle", 32'(ext_op), 0);
         chk("alu_op_idle", 32'(alu_op), 0);
      end else begin
         chk("ext_op", 32'(ext_op), 32'(ext));
         chk("alu_op", 32'(alu_op), 32'(alu));
      end
      if (e_mreq) chk("addr_sel", 32'(addr_sel), 32'(st == S_MEM));
      if (e_pcwe) chk("pc_src", 32'(pc_src), 32'(st == S_EXEC));
      if (e_rf)   chk("wb_sel", 32'(wb_sel), 32'(ld));
      chk("instret", 32'(instret), 32'(cnt_m));
      @(posedge clk);
      #1;
   endtask

   // Builds the expected cycle-by-cycle phase list for one instruction and walks it.
   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw);
      bit legal, ld, sto, br;
      logic [1:0] ext, alu;
      int st_q[$];
      bit rdy_q[$];
      op_info(ins[31:26], legal, ext, alu, ld, sto, br);
      for (int i = 0; i < fw; i++) begin st_q.push_back(S_FETCH); rdy_q.push_back(0); end
      st_q.push_back(S_FETCH);  rdy_q.push_back(1);
      st_q.push_back(S_DECODE); rdy_q.push_back(1'($urandom_range(0, 1)));
      if (!legal) begin
         for (int i = 0; i < 12; i++) begin
            st_q.push_back(S_TRAP); rdy_q.push_back(1'($urandom_range(0, 1)));
         end
      end else begin
         st_q.push_back(S_EXEC); rdy_q.push_back(1'($urandom_range(0, 1)));
         if (ld || sto) begin
            for (int i = 0; i < mw; i++) begin st_q.push_back(S_MEM); rdy_q.push_back(0); end
            st_q.push_back(S_MEM); rdy_q.push_back(1);
            if (ld) begin st_q.push_back(S_WB); rdy_q.push_back(1'($urandom_range(0, 1))); end
         end else if (!br) begin
            st_q.push_back(S_WB); rdy_q.push_back(1'($urandom_range(0, 1)));
         end
      end
      for (int i = 0; i < st_q.size(); i++) step(st_q[i], rdy_q[i], ins);
      if (legal) cnt_m = (cnt_m + 1) % (1 << W);
   endtask

   task automatic rst_cycle(input bit rdy);
      rst       = 1'b1;
      mem_ready = rdy;
      @(negedge clk);
      chk("rst_strobes", 32'({mem_req, mem_we, ir_we, pc_we, rf_we}), 0);
      chk("rst_ext_op", 32'(ext_op), 0);
      chk("rst_alu_op", 32'(alu_op), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic post_rst_check();
      cnt_m = 0;
      chk("rst_state", 32'(state), S_FETCH);
      chk("rst_instret", 32'(instret), 0);
      chk("rst_illegal", 32'(illegal), 0);
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr(input logic [5:0] op);
      logic [31:0] r;
      r = $urandom();
      return {op, r[25:0]};
   endfunction

   initial begin
      logic [5:0] ops[8];
      logic [5:0] op;
      int prev;
      ops = '{6'd14, 6'd15, 6'd24, 6'd25, 6'd28, 6'd32, 6'd36, 6'd18};
      n_cmp = 0; n_err = 0; cnt_m = 0;
      rst = 1'b1; mem_ready = 1'b1; instr = '0;

      @(posedge clk); #1;
      rst_cycle(1);
      rst_cycle(1);
      post_rst_check();

      run_instr(32'h3C20_1234, 0, 0);           // addis, 4 cycles
      chk("instret_after_addis", 32'(instret), 1);
      run_instr(rand_instr(6'd32), 0, 2);       // lwz, 7 cycles
      run_instr(rand_instr(6'd36), 0, 0);       // stw, 4 cycles
      run_instr(rand_instr(6'd18), 0, 0);       // b, 3 cycles
      run_instr(rand_instr(6'd24), 2, 0);

      // Enough traffic to carry the 8-bit counter through its wrap.
      for (int k = 0; k < 300; k++) begin
         op   = ops[$urandom_range(0, 7)];
         prev = cnt_m;
         run_instr(rand_instr(op), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
         if (prev == (1 << W) - 1) chk("instret_wrap", 32'(instret), 0);
      end

      run_instr(rand_instr(6'h3F), 1, 0);       // illegal -> TRAP
      rst_cycle(0);
      post_rst_check();

      run_instr(rand_instr(6'd14), 0, 0);
      run_instr(rand_instr(6'd28), 1, 1);
      step(S_FETCH, 0, rand_instr(6'd15));      // FETCH wait, then reset mid-access
      rst_cycle(1);
      post_rst_check();
      run_instr(rand_instr(6'd25), 0, 0);
      chk("instret_restart", 32'(instret), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
